// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one single-port 64-bit RAM between instruction fetch (read-only) and
// the data memory stage (read/write). Each access is sequenced through a
// fixed-latency RAM with a req/ack handshake per requester:
//
//   IDLE -> ISSUE -> [WAIT] -> ACK -> IDLE
//
// Data accesses have fixed priority. Fetch is protected from starvation: once
// STARVE_MAX data grants have been made in a row while fetch was waiting, the
// next arbitration goes to fetch.
//
// Parameters
//   RAM_LAT     cycles from the ram_en cycle to valid ram_rdata (>= 1)
//   STARVE_MAX  data grants allowed in a row while fetch is pending
//
// Ports
//   i_clk        system clock, all logic on the rising edge
//   i_rst        synchronous, active-high reset
//   i_if_req     fetch request, held until o_if_ack
//   i_if_addr    fetch address, stable while i_if_req is high
//   o_if_ack     one-cycle pulse: fetch done, o_if_rdata valid
//   o_if_rdata   fetched doubleword, held until the next fetch capture
//   i_mem_req    data request, held until o_mem_ack
//   i_mem_we     1 = write, 0 = read
//   i_mem_addr   data address
//   i_mem_wdata  write data
//   i_mem_wmask  per-bit write mask
//   o_mem_ack    one-cycle pulse: data access done (o_mem_rdata valid on reads)
//   o_mem_rdata  read data, held until the next data read capture
//   o_ram_en     RAM access strobe, exactly one cycle per access
//   o_ram_we     RAM write enable, qualified by o_ram_en
//   o_ram_addr   RAM address   (held outside the issue cycle)
//   o_ram_wdata  RAM write data (held outside the issue cycle)
//   o_ram_wmask  RAM write mask (held outside the issue cycle)
//   i_ram_rdata  RAM read data, valid RAM_LAT cycles after o_ram_en
//   o_busy       high whenever the arbiter is not idle
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int RAM_LAT    = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic        i_clk,
    input  logic        i_rst,

    input  logic        i_if_req,
    input  logic [63:0] i_if_addr,
    output logic        o_if_ack,
    output logic [63:0] o_if_rdata,

    input  logic        i_mem_req,
    input  logic        i_mem_we,
    input  logic [63:0] i_mem_addr,
    input  logic [63:0] i_mem_wdata,
    input  logic [63:0] i_mem_wmask,
    output logic        o_mem_ack,
    output logic [63:0] o_mem_rdata,

    output logic        o_ram_en,
    output logic        o_ram_we,
    output logic [63:0] o_ram_addr,
    output logic [63:0] o_ram_wdata,
    output logic [63:0] o_ram_wmask,
    input  logic [63:0] i_ram_rdata,

    output logic        o_busy
);

    // -------------------------------------------------------------------------
    // Local types and constants
    // -------------------------------------------------------------------------
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_ACK   = 2'd3
    } state_t;

    typedef enum logic {
        OWN_IF  = 1'b0,
        OWN_MEM = 1'b1
    } owner_t;

    // The latency counter only has to hold RAM_LAT-1; keep at least one bit.
    localparam int LAT_W = (RAM_LAT > 1) ? $clog2(RAM_LAT) : 1;
    // The starvation counter has to reach STARVE_MAX itself.
    localparam int STV_W = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;

    localparam logic [LAT_W-1:0] LAT_INIT   = LAT_W'(RAM_LAT - 1);
    localparam logic [STV_W-1:0] STARVE_LIM = STV_W'(STARVE_MAX);

    // -------------------------------------------------------------------------
    // State and registered outputs
    // -------------------------------------------------------------------------
    state_t            r_state;
    owner_t            r_owner;
    logic [LAT_W-1:0]  r_lat_cnt;
    logic [STV_W-1:0]  r_starve_cnt;

    logic              r_if_ack;
    logic [63:0]       r_if_rdata;
    logic              r_mem_ack;
    logic [63:0]       r_mem_rdata;

    logic              r_ram_en;
    logic              r_ram_we;
    logic [63:0]       r_ram_addr;
    logic [63:0]       r_ram_wdata;
    logic [63:0]       r_ram_wmask;
    logic              r_busy;

    // -------------------------------------------------------------------------
    // Arbitration decision for the IDLE cycle
    // -------------------------------------------------------------------------
    // Data wins unless fetch is waiting and has already been passed over
    // STARVE_MAX times in a row.
    logic w_mem_win;
    logic w_if_win;

    assign w_mem_win = i_mem_req && (!i_if_req || (r_starve_cnt < STARVE_LIM));
    assign w_if_win  = i_if_req && !w_mem_win;

    // -------------------------------------------------------------------------
    // Sequencer
    // -------------------------------------------------------------------------
    // Every output is a flop. Pulses (ram_en, ram_we, acks) are raised on the
    // transition *into* the state where they must be seen, so they line up
    // with ISSUE and ACK exactly, and default back to 0 on every other cycle.
    // NOTE: state is updated with non-blocking assignments so every branch
    // below reads the values from the start of the cycle, not partial updates.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            // NOTE: the datapath registers are cleared too, because every
            // output (including rdata and the ram_* buses) must read 0 after
            // reset; an in-flight access is simply dropped.
            r_state      <= S_IDLE;
            r_owner      <= OWN_IF;
            r_lat_cnt    <= '0;
            r_starve_cnt <= '0;
            r_if_ack     <= 1'b0;
            r_if_rdata   <= '0;
            r_mem_ack    <= 1'b0;
            r_mem_rdata  <= '0;
            r_ram_en     <= 1'b0;
            r_ram_we     <= 1'b0;
            r_ram_addr   <= '0;
            r_ram_wdata  <= '0;
            r_ram_wmask  <= '0;
            r_busy       <= 1'b0;
        end else begin
            // One-cycle strobes default low.
            r_ram_en  <= 1'b0;
            r_ram_we  <= 1'b0;
            r_if_ack  <= 1'b0;
            r_mem_ack <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (w_mem_win) begin
                        // The owner's request is latched straight into the
                        // RAM-facing registers; they then hold until the
                        // next grant.
                        r_owner     <= OWN_MEM;
                        r_ram_addr  <= i_mem_addr;
                        r_ram_wdata <= i_mem_wdata;
                        r_ram_wmask <= i_mem_wmask;
                        r_ram_en    <= 1'b1;
                        r_ram_we    <= i_mem_we;
                        r_state     <= S_ISSUE;
                        r_busy      <= 1'b1;
                        // Count data grants that made fetch wait; a grant
                        // with no fetch pending ends the streak.
                        if (i_if_req) begin
                            if (r_starve_cnt != STARVE_LIM) begin
                                r_starve_cnt <= r_starve_cnt + 1'b1;
                            end
                        end else begin
                            r_starve_cnt <= '0;
                        end
                    end else if (w_if_win) begin
                        // A fetch is always a read; the write buses carry 0.
                        r_owner      <= OWN_IF;
                        r_ram_addr   <= i_if_addr;
                        r_ram_wdata  <= '0;
                        r_ram_wmask  <= '0;
                        r_ram_en     <= 1'b1;
                        r_ram_we     <= 1'b0;
                        r_state      <= S_ISSUE;
                        r_busy       <= 1'b1;
                        r_starve_cnt <= '0;
                    end
                end

                S_ISSUE: begin
                    // r_ram_we is still the value for this access here.
                    if (r_ram_we) begin
                        // Writes complete on the issue edge; nothing to wait for.
                        r_mem_ack <= (r_owner == OWN_MEM);
                        r_if_ack  <= (r_owner == OWN_IF);
                        r_state   <= S_ACK;
                    end else begin
                        r_lat_cnt <= LAT_INIT;
                        r_state   <= S_WAIT;
                    end
                end

                S_WAIT: begin
                    if (r_lat_cnt == '0) begin
                        // Only the owner's rdata register changes; the
                        // other keeps its last fetched/loaded value.
                        if (r_owner == OWN_MEM) begin
                            r_mem_rdata <= i_ram_rdata;
                            r_mem_ack   <= 1'b1;
                        end else begin
                            r_if_rdata  <= i_ram_rdata;
                            r_if_ack    <= 1'b1;
                        end
                        r_state <= S_ACK;
                    end else begin
                        r_lat_cnt <= r_lat_cnt - 1'b1;
                    end
                end

                S_ACK: begin
                    // Requests are ignored here; a held request is picked up
                    // in the IDLE cycle that follows.
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end

                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Output wiring
    // -------------------------------------------------------------------------
    assign o_if_ack    = r_if_ack;
    assign o_if_rdata  = r_if_rdata;
    assign o_mem_ack   = r_mem_ack;
    assign o_mem_rdata = r_mem_rdata;
    assign o_ram_en    = r_ram_en;
    assign o_ram_we    = r_ram_we;
    assign o_ram_addr  = r_ram_addr;
    assign o_ram_wdata = r_ram_wdata;
    assign o_ram_wmask = r_ram_wmask;
    assign o_busy      = r_busy;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Directed bench for mem_port_arbiter with default parameters
// (RAM_LAT = 2, STARVE_MAX = 4). Inputs are driven and outputs sampled on the
// falling edge; "Nk" in the comments is the k-th falling edge after the one
// on which a request was raised, i.e. the middle of cycle T+k.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

    logic        clk;
    logic        rst;
    logic        if_req;
    logic [63:0] if_addr;
    logic        if_ack;
    logic [63:0] if_rdata;
    logic        mem_req;
    logic        mem_we;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic [63:0] mem_wmask;
    logic        mem_ack;
    logic [63:0] mem_rdata;
    logic        ram_en;
    logic        ram_we;
    logic [63:0] ram_addr;
    logic [63:0] ram_wdata;
    logic [63:0] ram_wmask;
    logic [63:0] ram_rdata;
    logic        busy;

    int total = 0;
    int bad   = 0;
    int n_if_ack  = 0;
    int n_mem_ack = 0;

    localparam logic [63:0] D_FETCH = 64'h0000_0013_0000_0093;
    localparam logic [63:0] D_10    = 64'h1111_2222_3333_4444;
    localparam logic [63:0] D_18    = 64'h5555_6666_7777_8888;

    mem_port_arbiter #(
        .RAM_LAT    (2),
        .STARVE_MAX (4)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_if_req    (if_req),
        .i_if_addr   (if_addr),
        .o_if_ack    (if_ack),
        .o_if_rdata  (if_rdata),
        .i_mem_req   (mem_req),
        .i_mem_we    (mem_we),
        .i_mem_addr  (mem_addr),
        .i_mem_wdata (mem_wdata),
        .i_mem_wmask (mem_wmask),
        .o_mem_ack   (mem_ack),
        .o_mem_rdata (mem_rdata),
        .o_ram_en    (ram_en),
        .o_ram_we    (ram_we),
        .o_ram_addr  (ram_addr),
        .o_ram_wdata (ram_wdata),
        .o_ram_wmask (ram_wmask),
        .i_ram_rdata (ram_rdata),
        .o_busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Read-only RAM model with a two-cycle read latency: data for a read
    // strobed in cycle C is presented throughout cycle C+2 and held after.
    function automatic logic [63:0] rom(input logic [63:0] a);
        case (a)
            64'h0000_0000_8000_0000: rom = D_FETCH;
            64'h0000_0000_0000_0010: rom = D_10;
            64'h0000_0000_0000_0018: rom = D_18;
            default:                 rom = 64'hBAD0_BAD0_BAD0_BAD0;
        endcase
    endfunction

    logic [63:0] rd_stage;
    always @(posedge clk) begin
        if (ram_en && !ram_we) rd_stage <= rom(ram_addr);
        ram_rdata <= rd_stage;
    end

    // Count every cycle an ack is high; one-cycle pulses make this the
    // number of completed accesses.
    always @(negedge clk) begin
        if (if_ack)  n_if_ack  <= n_if_ack + 1;
        if (mem_ack) n_mem_ack <= n_mem_ack + 1;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Hard stop if something hangs outside the bounded loops.
    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    logic [5:0] seq;
    int         nacks;
    int         stray;

    initial begin
        rst       = 1'b1;
        if_req    = 1'b0;
        if_addr   = '0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_wmask = '0;

        // ---------------- reset state ----------------
        tick(); tick();
        check("rst_busy",    busy,      0);
        check("rst_ram_en",  ram_en,    0);
        check("rst_ram_adr", ram_addr,  0);
        check("rst_acks",    {if_ack, mem_ack}, 0);
        check("rst_rdata",   if_rdata | mem_rdata, 0);
        rst = 1'b0;
        tick();

        // ---------------- IF read ----------------
        if_req = 1'b1; if_addr = 64'h8000_0000;        // N0: sampled at T
        tick();                                        // N1
        check("if_rd_en",   ram_en,   1);
        check("if_rd_we",   ram_we,   0);
        check("if_rd_addr", ram_addr, 64'h8000_0000);
        check("if_rd_busy", busy,     1);
        tick();                                        // N2
        check("if_rd_en_off", ram_en, 0);
        tick();                                        // N3
        check("if_rd_noack", if_ack,  0);
        tick();                                        // N4
        check("if_rd_ack",   if_ack,   1);
        check("if_rd_data",  if_rdata, D_FETCH);
        check("if_rd_mack",  mem_ack,  0);
        if_req = 1'b0;
        tick();                                        // N5
        check("if_rd_ack_off", if_ack, 0);
        check("if_rd_idle",    busy,   0);

        // ---------------- MEM write ----------------
        mem_req = 1'b1; mem_we = 1'b1; mem_addr = 64'h8000_1000;
        mem_wdata = 64'hDEAD_BEEF; mem_wmask = 64'hFFFF_FFFF;
        tick();                                        // N1
        check("wr_en",    ram_en,    1);
        check("wr_we",    ram_we,    1);
        check("wr_addr",  ram_addr,  64'h8000_1000);
        check("wr_wdata", ram_wdata, 64'hDEAD_BEEF);
        check("wr_wmask", ram_wmask, 64'hFFFF_FFFF);
        tick();                                        // N2
        check("wr_ack",    mem_ack, 1);
        check("wr_if_ack", if_ack,  0);
        check("wr_en_off", ram_en,  0);
        check("wr_we_off", ram_we,  0);
        check("wr_no_rd",  mem_rdata, 0);
        check("wr_addr_hold", ram_addr, 64'h8000_1000);
        mem_req = 1'b0; mem_we = 1'b0;
        tick();                                        // N3
        check("wr_ack_off", mem_ack, 0);
        check("wr_idle",    busy,    0);

        // ---------------- simultaneous requests ----------------
        if_req = 1'b1; if_addr = 64'h8000_0000;
        mem_req = 1'b1; mem_we = 1'b0; mem_addr = 64'h10;
        tick();                                        // N1
        check("sim_mem_first", ram_addr, 64'h10);
        check("sim_en1",       ram_en,   1);
        tick(); tick(); tick();                        // N4
        check("sim_mack",  mem_ack,   1);
        check("sim_iack0", if_ack,    0);
        check("sim_mdata", mem_rdata, D_10);
        mem_req = 1'b0;
        tick();                                        // N5: IDLE, IF sampled
        check("sim_gap_en", ram_en, 0);
        tick();                                        // N6: IF ISSUE
        check("sim_if_en",   ram_en,   1);
        check("sim_if_addr", ram_addr, 64'h8000_0000);
        tick(); tick(); tick();                        // N9
        check("sim_iack",  if_ack,  1);
        check("sim_mack0", mem_ack, 0);
        if_req = 1'b0;
        tick();
        check("sim_idle", busy, 0);

        // ---------------- back-to-back MEM reads ----------------
        mem_req = 1'b1; mem_we = 1'b0; mem_addr = 64'h10;
        tick(); tick(); tick(); tick();                // N4
        check("b2b_ack1",  mem_ack,   1);
        check("b2b_data1", mem_rdata, D_10);
        mem_addr = 64'h18;                             // request stays high
        tick();                                        // N5: IDLE resample
        check("b2b_busy_gap", busy, 0);
        tick();                                        // N6: second ISSUE
        check("b2b_addr2", ram_addr, 64'h18);
        tick(); tick();                                // N8
        check("b2b_noack",  mem_ack,   0);
        check("b2b_hold",   mem_rdata, D_10);
        tick();                                        // N9: 5 cycles after first ack
        check("b2b_ack2",  mem_ack,   1);
        check("b2b_data2", mem_rdata, D_18);
        mem_req = 1'b0;
        tick();

        // ---------------- starvation limit ----------------
        seq = '0; nacks = 0;
        if_req = 1'b1; if_addr = 64'h8000_0000;
        mem_req = 1'b1; mem_we = 1'b0; mem_addr = 64'h18;
        for (int c = 0; c < 80 && nacks < 6; c++) begin
            tick();
            if (mem_ack) begin seq = {seq[4:0], 1'b1}; nacks++; end
            if (if_ack)  begin seq = {seq[4:0], 1'b0}; nacks++; if_req = 1'b0; end
            if (nacks == 6) mem_req = 1'b0;
        end
        mem_req = 1'b0; if_req = 1'b0;
        check("stv_count", nacks, 6);
        check("stv_order", seq,   6'b111101);          // M M M M I M
        tick(); tick();
        check("stv_idle",  busy,      0);
        check("stv_mdata", mem_rdata, D_18);

        // ---------------- reset during an IF read ----------------
        if_req = 1'b1; if_addr = 64'h8000_0000;
        tick();                                        // N1: ISSUE
        tick();                                        // N2: WAIT
        rst = 1'b1;
        tick();                                        // N3
        check("ra_busy",  busy,      0);
        check("ra_acks",  {if_ack, mem_ack}, 0);
        check("ra_ifrd",  if_rdata,  0);
        check("ra_mrd",   mem_rdata, 0);
        check("ra_raddr", ram_addr,  0);
        tick();                                        // N4: second reset edge done
        rst = 1'b0; if_req = 1'b0;
        stray = 0;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (if_ack || mem_ack || ram_en) stray++;
        end
        check("ra_no_ack",   stray,    0);
        check("ra_ifrd_hold", if_rdata, 0);
        check("ra_idle",      busy,     0);

        // ---------------- ack totals ----------------
        check("tot_if_acks",  n_if_ack,  3);
        check("tot_mem_acks", n_mem_ack, 9);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
